// File: rtl/scanout_pkg.sv
// Shared widths, default raster timing and FSM states for the row scanout stage.
package scanout_pkg;

  localparam int RGB_W      = 24;
  localparam int ROW_ADDR_W = 9;

  localparam int DEF_H_ACTIVE = 320;
  localparam int DEF_H_FRONT  = 8;
  localparam int DEF_H_SYNC   = 32;
  localparam int DEF_H_BACK   = 40;
  localparam int DEF_V_ACTIVE = 240;
  localparam int DEF_V_FRONT  = 3;
  localparam int DEF_V_SYNC   = 4;
  localparam int DEF_V_BACK   = 15;

  localparam logic [RGB_W-1:0] DEF_BG_COLOR = 24'h000000;

  typedef enum logic {
    INIT,
    RUN
  } scan_state_t;

endpackage

// File: rtl/line_ram.sv
// 512x24 simple dual-port line buffer: one write port, one registered read port.
// Read data appears one clock after the address; neither port ever stalls.
module line_ram
  import scanout_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [ROW_ADDR_W-1:0] i_waddr,
  input  logic [RGB_W-1:0]      i_wdat,
  input  logic [ROW_ADDR_W-1:0] i_raddr,
  output logic [RGB_W-1:0]      o_rdat
);

  localparam int DEPTH = 1 << ROW_ADDR_W;

  logic [RGB_W-1:0] r_mem [DEPTH];
  logic [RGB_W-1:0] r_rdat;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdat;
    r_rdat <= r_mem[i_raddr];
  end

  assign o_rdat = r_rdat;

endmodule

// File: rtl/row_scanout.sv
// Ping-pong line buffers scanned out as a VGA-style stream with clear-on-read; swap/swap_screen pace the drawer.
// 1 clk from h/v counters to pixel/sync outputs; no backpressure. ROW_SCANOUT_BORDER_EN forces a white frame border.
module row_scanout
  import scanout_pkg::*;
#(
  parameter int               H_ACTIVE = DEF_H_ACTIVE,
  parameter int               H_FRONT  = DEF_H_FRONT,
  parameter int               H_SYNC   = DEF_H_SYNC,
  parameter int               H_BACK   = DEF_H_BACK,
  parameter int               V_ACTIVE = DEF_V_ACTIVE,
  parameter int               V_FRONT  = DEF_V_FRONT,
  parameter int               V_SYNC   = DEF_V_SYNC,
  parameter int               V_BACK   = DEF_V_BACK,
  parameter logic [RGB_W-1:0] BG_COLOR = DEF_BG_COLOR
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ROW_ADDR_W-1:0] address_write_row,
  input  logic [RGB_W-1:0]      data_write_row,
  input  logic                  write_row_en,
  output logic                  swap,
  output logic                  swap_screen,
  output logic [RGB_W-1:0]      pixel_rgb,
  output logic                  pixel_valid,
  output logic                  hsync,
  output logic                  vsync
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int AW1     = ROW_ADDR_W + 1;

  localparam logic [HW-1:0]         H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0]         H_ACT      = HW'(H_ACTIVE);
  localparam logic [HW-1:0]         HS_BEG     = HW'(H_ACTIVE + H_FRONT);
  localparam logic [HW-1:0]         HS_END     = HW'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [VW-1:0]         V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0]         V_ACT      = VW'(V_ACTIVE);
  localparam logic [VW-1:0]         V_ACT_LAST = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0]         VS_BEG     = VW'(V_ACTIVE + V_FRONT);
  localparam logic [VW-1:0]         VS_END     = VW'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [ROW_ADDR_W-1:0] A_LAST     = ROW_ADDR_W'(H_ACTIVE - 1);
  localparam logic [AW1-1:0]        WR_LIMIT   = AW1'(H_ACTIVE);

  scan_state_t             r_state;
  scan_state_t             w_state_nxt;
  logic [ROW_ADDR_W-1:0]   r_clr_cnt;
  logic [HW-1:0]           r_h;
  logic [VW-1:0]           r_v;
  logic                    r_front_sel;
  logic                    r_rd_sel;
  logic                    r_valid;
  logic                    r_hsync;
  logic                    r_vsync;

  logic                    w_run;
  logic                    w_h_act;
  logic                    w_swap;
  logic                    w_swap_screen;
  logic                    w_scan_clr;
  logic [ROW_ADDR_W-1:0]   w_scan_addr;
  logic                    w_drw_we;
  logic [ROW_ADDR_W-1:0]   w_rd_addr;
  logic [1:0]              w_we;
  logic [1:0][ROW_ADDR_W-1:0] w_waddr;
  logic [1:0][RGB_W-1:0]   w_wdat;
  logic [1:0][RGB_W-1:0]   w_rdat;
  logic [RGB_W-1:0]        w_pix;

  assign w_run       = (r_state == RUN);
  assign w_h_act     = (r_h < H_ACT);
  assign w_rd_addr   = ROW_ADDR_W'(r_h);
  // Clear trails the read by one clock: address h-1 is wiped while h is read.
  assign w_scan_clr  = w_run && (r_h != '0) && (r_h <= H_ACT);
  assign w_scan_addr = ROW_ADDR_W'(r_h - 1'b1);
  assign w_drw_we    = w_run && write_row_en && ({1'b0, address_write_row} < WR_LIMIT);

  always_ff @(posedge clk) begin
    if (reset) r_state <= INIT;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_swap        = 1'b0;
    w_swap_screen = 1'b0;
    case (r_state)
      INIT: if (r_clr_cnt == A_LAST) w_state_nxt = RUN;
      RUN: begin
        if (r_h == '0) begin
          if (r_v == V_LAST)          w_swap_screen = 1'b1;
          else if (r_v < V_ACT_LAST)  w_swap        = 1'b1;
        end
      end
    endcase
  end

  // front_sel flips on entry to h==0, so the h==0 cycle already sees the new pairing.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_clr_cnt   <= '0;
      r_h         <= '0;
      r_v         <= V_LAST;
      r_front_sel <= 1'b0;
    end else if (r_state == INIT) begin
      r_clr_cnt <= r_clr_cnt + 1'b1;
      r_h       <= '0;
      r_v       <= V_LAST;
      if (w_state_nxt == RUN) r_front_sel <= ~r_front_sel;
    end else if (r_h == H_LAST) begin
      r_h         <= '0;
      r_v         <= (r_v == V_LAST) ? '0 : r_v + 1'b1;
      r_front_sel <= ~r_front_sel;
    end else begin
      r_h <= r_h + 1'b1;
    end
  end

  always_comb begin
    w_we    = '0;
    w_waddr = '0;
    w_wdat  = '0;
    if (r_state == INIT) begin
      w_we    = 2'b11;
      w_waddr = {2{r_clr_cnt}};
      w_wdat  = {2{BG_COLOR}};
    end else begin
      w_we[r_front_sel]     = w_scan_clr;
      w_waddr[r_front_sel]  = w_scan_addr;
      w_wdat[r_front_sel]   = BG_COLOR;
      w_we[~r_front_sel]    = w_drw_we;
      w_waddr[~r_front_sel] = address_write_row;
      w_wdat[~r_front_sel]  = data_write_row;
    end
  end

  line_ram u_ram0 (
    .i_clk   (clk),
    .i_we    (w_we[0]),
    .i_waddr (w_waddr[0]),
    .i_wdat  (w_wdat[0]),
    .i_raddr (w_rd_addr),
    .o_rdat  (w_rdat[0])
  );

  line_ram u_ram1 (
    .i_clk   (clk),
    .i_we    (w_we[1]),
    .i_waddr (w_waddr[1]),
    .i_wdat  (w_wdat[1]),
    .i_raddr (w_rd_addr),
    .o_rdat  (w_rdat[1])
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid  <= 1'b0;
      r_hsync  <= 1'b1;
      r_vsync  <= 1'b1;
      r_rd_sel <= 1'b0;
    end else begin
      r_valid  <= w_run && w_h_act && (r_v < V_ACT);
      r_hsync  <= !(w_run && (r_h >= HS_BEG) && (r_h < HS_END));
      r_vsync  <= !(w_run && (r_v >= VS_BEG) && (r_v < VS_END));
      r_rd_sel <= r_front_sel;
    end
  end

`ifdef ROW_SCANOUT_BORDER_EN
  localparam logic [HW-1:0] H_ACT_LAST = HW'(H_ACTIVE - 1);

  logic r_border;

  always_ff @(posedge clk) begin
    if (reset) r_border <= 1'b0;
    else       r_border <= (r_h == '0) || (r_h == H_ACT_LAST) || (r_v == '0) || (r_v == V_ACT_LAST);
  end

  assign w_pix = r_border ? {RGB_W{1'b1}} : w_rdat[r_rd_sel];
`else
  assign w_pix = w_rdat[r_rd_sel];
`endif

  assign pixel_rgb   = r_valid ? w_pix : '0;
  assign pixel_valid = r_valid;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign swap        = w_swap;
  assign swap_screen = w_swap_screen;

endmodule

// File: tb/tb_row_scanout.sv
// Directed bench for row_scanout: reset, INIT pacing, drawer writes, clear-on-read, syncs, frame pacing, mid-frame reset.
module tb_row_scanout;

  localparam int H_ACTIVE = 320;
  localparam int H_FRONT  = 8;
  localparam int H_SYNC   = 32;
  localparam int H_BACK   = 40;
  localparam int H_TOTAL  = 400;
  // Vertical timing is shortened to 46 lines so a whole frame stays a short run.
  localparam int V_ACTIVE = 24;
  localparam int V_FRONT  = 3;
  localparam int V_SYNC   = 4;
  localparam int V_BACK   = 15;
  localparam int V_TOTAL  = 46;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [8:0]  address_write_row = '0;
  logic [23:0] data_write_row = '0;
  logic        write_row_en = 1'b0;
  logic        swap, swap_screen, pixel_valid, hsync, vsync;
  logic [23:0] pixel_rgb;

  int n_vec = 0;
  int n_bad = 0;

  // Position the DUT counters should hold after the most recent edge (m_*),
  // and the position those registered outputs describe (p_*).
  bit m_run = 1'b0;
  int m_c = 0, m_h = 0, m_v = 0;
  int p_h = 0, p_v = 0;

  logic [23:0] cap_rgb [H_TOTAL];
  logic        cap_vld [H_TOTAL];
  logic        cap_hs  [H_TOTAL];
  logic        cap_vs  [H_TOTAL];

  row_scanout #(
    .H_ACTIVE (H_ACTIVE), .H_FRONT (H_FRONT), .H_SYNC (H_SYNC), .H_BACK (H_BACK),
    .V_ACTIVE (V_ACTIVE), .V_FRONT (V_FRONT), .V_SYNC (V_SYNC), .V_BACK (V_BACK),
    .BG_COLOR (24'h000000)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .address_write_row (address_write_row),
    .data_write_row    (data_write_row),
    .write_row_en      (write_row_en),
    .swap              (swap),
    .swap_screen       (swap_screen),
    .pixel_rgb         (pixel_rgb),
    .pixel_valid       (pixel_valid),
    .hsync             (hsync),
    .vsync             (vsync)
  );

  always #5 clk = ~clk;

  task automatic tick();
    p_h = m_h;
    p_v = m_v;
    @(posedge clk);
    #1;
    if (reset) begin
      m_run = 1'b0;
      m_c   = 0;
    end else if (!m_run) begin
      if (m_c == H_ACTIVE - 1) begin
        m_run = 1'b1;
        m_h   = 0;
        m_v   = V_TOTAL - 1;
      end else begin
        m_c++;
      end
    end else if (m_h == H_TOTAL - 1) begin
      m_h = 0;
      m_v = (m_v == V_TOTAL - 1) ? 0 : m_v + 1;
    end else begin
      m_h++;
    end
  endtask

  task automatic advance_to(input int v, input int h);
    int n = 0;
    while (!(m_run && m_v == v && m_h == h) && n < 2 * V_TOTAL * H_TOTAL) begin
      tick();
      n++;
    end
  endtask

  task automatic capture_line();
    for (int k = 0; k < H_TOTAL; k++) begin
      tick();
      cap_rgb[p_h] = pixel_rgb;
      cap_vld[p_h] = pixel_valid;
      cap_hs[p_h]  = hsync;
      cap_vs[p_h]  = vsync;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    n_vec++; if (pixel_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", pixel_valid); end
    n_vec++; if (pixel_rgb !== 24'h0) begin n_bad++; $display("FAIL reset_rgb: got %h want 000000", pixel_rgb); end
    n_vec++; if (hsync !== 1'b1) begin n_bad++; $display("FAIL reset_hsync: got %b want 1", hsync); end
    n_vec++; if (vsync !== 1'b1) begin n_bad++; $display("FAIL reset_vsync: got %b want 1", vsync); end
    n_vec++; if (swap !== 1'b0) begin n_bad++; $display("FAIL reset_swap: got %b want 0", swap); end
    n_vec++; if (swap_screen !== 1'b0) begin n_bad++; $display("FAIL reset_swap_screen: got %b want 0", swap_screen); end
  endtask

  task automatic test_init();
    int ss_cnt = 0, sw_cnt = 0, sync_low = 0, vld_cnt = 0, first_ss = -1;
    // Drawer writes during INIT must be ignored; line 0/1 checks later catch a leak at x=20.
    write_row_en      = 1'b1;
    address_write_row = 9'd20;
    data_write_row    = 24'h555555;
    reset = 1'b0;
    for (int i = 1; i <= H_ACTIVE; i++) begin
      tick();
      if (swap_screen === 1'b1) begin ss_cnt++; if (first_ss < 0) first_ss = i; end
      if (swap !== 1'b0) sw_cnt++;
      if (hsync !== 1'b1 || vsync !== 1'b1) sync_low++;
      if (pixel_valid !== 1'b0) vld_cnt++;
    end
    write_row_en = 1'b0;
    n_vec++; if (first_ss != H_ACTIVE) begin n_bad++; $display("FAIL init_ss_cycle: got %0d want %0d", first_ss, H_ACTIVE); end
    n_vec++; if (ss_cnt != 1) begin n_bad++; $display("FAIL init_ss_count: got %0d want 1", ss_cnt); end
    n_vec++; if (sw_cnt != 0) begin n_bad++; $display("FAIL init_swap_count: got %0d want 0", sw_cnt); end
    n_vec++; if (sync_low != 0) begin n_bad++; $display("FAIL init_sync: got %0d low cycles want 0", sync_low); end
    n_vec++; if (vld_cnt != 0) begin n_bad++; $display("FAIL init_valid: got %0d valid cycles want 0", vld_cnt); end
  endtask

  task automatic test_write_pixel();
    int other = 0, vbad = 0;
    address_write_row = 9'd10;
    data_write_row    = 24'h12AB34;
    write_row_en      = 1'b1;
    tick();
    write_row_en = 1'b0;
    advance_to(0, 0);
    capture_line();
    for (int h = 0; h < H_TOTAL; h++) begin
      if (h != 10 && cap_rgb[h] !== 24'h0) other++;
      if (cap_vld[h] !== (h < H_ACTIVE)) vbad++;
    end
    n_vec++; if (cap_rgb[10] !== 24'h12AB34) begin n_bad++; $display("FAIL write_px10: got %h want 12ab34", cap_rgb[10]); end
    n_vec++; if (cap_vld[10] !== 1'b1) begin n_bad++; $display("FAIL write_vld10: got %b want 1", cap_vld[10]); end
    n_vec++; if (cap_rgb[9] !== 24'h0) begin n_bad++; $display("FAIL write_px9: got %h want 000000", cap_rgb[9]); end
    n_vec++; if (cap_rgb[11] !== 24'h0) begin n_bad++; $display("FAIL write_px11: got %h want 000000", cap_rgb[11]); end
    n_vec++; if (other != 0) begin n_bad++; $display("FAIL write_others: got %0d nonzero pixels want 0", other); end
    n_vec++; if (vbad != 0) begin n_bad++; $display("FAIL write_valid_window: got %0d wrong valid bits want 0", vbad); end
  endtask

  task automatic test_clear_on_read();
    int nz1 = 0, nz2 = 0;
    capture_line();
    for (int h = 0; h < H_TOTAL; h++) if (cap_rgb[h] !== 24'h0) nz1++;
    n_vec++; if (nz1 != 0) begin n_bad++; $display("FAIL clear_line1: got %0d nonzero pixels want 0", nz1); end
    capture_line();
    for (int h = 0; h < H_TOTAL; h++) if (cap_rgb[h] !== 24'h0) nz2++;
    n_vec++; if (cap_rgb[10] !== 24'h0) begin n_bad++; $display("FAIL clear_px10: got %h want 000000", cap_rgb[10]); end
    n_vec++; if (nz2 != 0) begin n_bad++; $display("FAIL clear_line2: got %0d nonzero pixels want 0", nz2); end
  endtask

  task automatic test_drop();
    int nz = 0;
    data_write_row = 24'hFFFFFF;
    write_row_en   = 1'b1;
    for (int k = 0; k < H_TOTAL; k++) begin
      address_write_row = (k < H_TOTAL / 2) ? 9'd320 : 9'd400;
      tick();
    end
    write_row_en = 1'b0;
    capture_line();
    for (int h = 0; h < H_TOTAL; h++) if (cap_rgb[h] !== 24'h0) nz++;
    n_vec++; if (nz != 0) begin n_bad++; $display("FAIL drop_oob: got %0d nonzero pixels want 0", nz); end
  endtask

  task automatic test_edges();
    write_row_en = 1'b1;
    address_write_row = 9'd0;   data_write_row = 24'hAABBCC; tick();
    address_write_row = 9'd319; data_write_row = 24'h010203; tick();
    address_write_row = 9'd160; data_write_row = 24'hC0FFEE; tick();
    write_row_en = 1'b0;
    advance_to(6, 0);
    capture_line();
    n_vec++; if (cap_rgb[0] !== 24'hAABBCC) begin n_bad++; $display("FAIL edge_px0: got %h want aabbcc", cap_rgb[0]); end
    n_vec++; if (cap_rgb[319] !== 24'h010203) begin n_bad++; $display("FAIL edge_px319: got %h want 010203", cap_rgb[319]); end
    n_vec++; if (cap_rgb[160] !== 24'hC0FFEE) begin n_bad++; $display("FAIL edge_px160: got %h want c0ffee", cap_rgb[160]); end
    n_vec++; if (cap_vld[319] !== 1'b1) begin n_bad++; $display("FAIL edge_vld319: got %b want 1", cap_vld[319]); end
    n_vec++; if (cap_vld[320] !== 1'b0 || cap_rgb[320] !== 24'h0) begin n_bad++; $display("FAIL edge_px320: got vld=%b rgb=%h want 0/000000", cap_vld[320], cap_rgb[320]); end
  endtask

  task automatic test_hsync();
    int lows = 0, vlows = 0;
    capture_line();
    for (int h = 0; h < H_TOTAL; h++) begin
      if (cap_hs[h] === 1'b0) lows++;
      if (cap_vs[h] !== 1'b1) vlows++;
    end
    n_vec++; if (lows != H_SYNC) begin n_bad++; $display("FAIL hsync_width: got %0d want %0d", lows, H_SYNC); end
    n_vec++; if (cap_hs[327] !== 1'b1) begin n_bad++; $display("FAIL hsync_h327: got %b want 1", cap_hs[327]); end
    n_vec++; if (cap_hs[328] !== 1'b0) begin n_bad++; $display("FAIL hsync_h328: got %b want 0", cap_hs[328]); end
    n_vec++; if (cap_hs[359] !== 1'b0) begin n_bad++; $display("FAIL hsync_h359: got %b want 0", cap_hs[359]); end
    n_vec++; if (cap_hs[360] !== 1'b1) begin n_bad++; $display("FAIL hsync_h360: got %b want 1", cap_hs[360]); end
    n_vec++; if (vlows != 0) begin n_bad++; $display("FAIL hsync_line_vsync: got %0d low cycles want 0", vlows); end
  endtask

  task automatic test_full_frame();
    int sw = 0, ss = 0, both = 0, tbad = 0, vld = 0, vsbad = 0;
    int vs_low [V_TOTAL];
    bit exp_sw, exp_ss;
    for (int v = 0; v < V_TOTAL; v++) vs_low[v] = 0;
    for (int n = 0; n < V_TOTAL * H_TOTAL; n++) begin
      tick();
      exp_sw = m_run && (m_h == 0) && (m_v < V_ACTIVE - 1);
      exp_ss = m_run && (m_h == 0) && (m_v == V_TOTAL - 1);
      if (swap === 1'b1) sw++;
      if (swap_screen === 1'b1) ss++;
      if (swap === 1'b1 && swap_screen === 1'b1) both++;
      if (swap !== exp_sw || swap_screen !== exp_ss) tbad++;
      if (pixel_valid === 1'b1) vld++;
      if (vsync === 1'b0) vs_low[p_v]++;
    end
    for (int v = 0; v < V_TOTAL; v++)
      if (vs_low[v] != ((v >= V_ACTIVE + V_FRONT && v < V_ACTIVE + V_FRONT + V_SYNC) ? H_TOTAL : 0)) vsbad++;
    n_vec++; if (sw != V_ACTIVE - 1) begin n_bad++; $display("FAIL frame_swaps: got %0d want %0d", sw, V_ACTIVE - 1); end
    n_vec++; if (ss != 1) begin n_bad++; $display("FAIL frame_swap_screen: got %0d want 1", ss); end
    n_vec++; if (both != 0) begin n_bad++; $display("FAIL frame_overlap: got %0d want 0", both); end
    n_vec++; if (tbad != 0) begin n_bad++; $display("FAIL frame_pulse_timing: got %0d misplaced cycles want 0", tbad); end
    n_vec++; if (vld != V_ACTIVE * H_ACTIVE) begin n_bad++; $display("FAIL frame_valid: got %0d want %0d", vld, V_ACTIVE * H_ACTIVE); end
    n_vec++; if (vs_low[27] != H_TOTAL || vs_low[30] != H_TOTAL) begin n_bad++; $display("FAIL vsync_inside: got %0d/%0d want %0d", vs_low[27], vs_low[30], H_TOTAL); end
    n_vec++; if (vs_low[26] != 0 || vs_low[31] != 0) begin n_bad++; $display("FAIL vsync_outside: got %0d/%0d want 0", vs_low[26], vs_low[31]); end
    n_vec++; if (vsbad != 0) begin n_bad++; $display("FAIL vsync_lines: got %0d wrong lines want 0", vsbad); end
  endtask

  task automatic test_reset_midline();
    int n = 0, nz = 0, vld = 0;
    advance_to(12, 0);
    address_write_row = 9'd200;
    data_write_row    = 24'h777777;
    write_row_en      = 1'b1;
    tick();
    write_row_en = 1'b0;
    advance_to(12, 150);
    n_vec++; if (pixel_valid !== 1'b1) begin n_bad++; $display("FAIL pre_reset_valid: got %b want 1", pixel_valid); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_vec++; if (pixel_valid !== 1'b0 || pixel_rgb !== 24'h0) begin n_bad++; $display("FAIL midreset_pixel: got vld=%b rgb=%h want 0/000000", pixel_valid, pixel_rgb); end
    n_vec++; if (hsync !== 1'b1 || vsync !== 1'b1) begin n_bad++; $display("FAIL midreset_sync: got hs=%b vs=%b want 1/1", hsync, vsync); end
    n_vec++; if (swap !== 1'b0 || swap_screen !== 1'b0) begin n_bad++; $display("FAIL midreset_pulses: got sw=%b ss=%b want 0/0", swap, swap_screen); end
    do begin
      tick();
      n++;
    end while (swap_screen !== 1'b1 && n < 1000);
    n_vec++; if (n != H_ACTIVE) begin n_bad++; $display("FAIL midreset_reinit: swap_screen after %0d cycles want %0d", n, H_ACTIVE); end
    advance_to(0, 0);
    for (int l = 0; l < 2; l++) begin
      capture_line();
      for (int h = 0; h < H_TOTAL; h++) begin
        if (cap_rgb[h] !== 24'h0) nz++;
        if (cap_vld[h] === 1'b1) vld++;
      end
    end
    n_vec++; if (nz != 0) begin n_bad++; $display("FAIL midreset_stale: got %0d nonzero pixels want 0", nz); end
    n_vec++; if (vld != 2 * H_ACTIVE) begin n_bad++; $display("FAIL midreset_valid: got %0d want %0d", vld, 2 * H_ACTIVE); end
  endtask

  initial begin
    test_reset();
    test_init();
    test_write_pixel();
    test_clear_on_read();
    test_drop();
    test_edges();
    test_hsync();
    test_full_frame();
    test_reset_midline();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
